mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store sequencer between the MIPS execute/memory pipeline stage and the word-wide data memory.
- Accepts byte, halfword and word accesses at byte addresses and checks alignment.
- Drives the memory's word interface: Clk, CS, RW, BE, Addr[31:2], DataIn, DataOut, DataReady.
- Sub-word stores are done as read-modify-write, because the memory zeroes unselected lanes on write. Load data is lane-extracted and sign- or zero-extended here.

Parameters:
RMW_EN, 1, 1: sub-word stores use read-merge-write; 0: single write with natural BE (lane zeroing accepted)
TIMEOUT, 15, max cycles waited for MemDataReady before BusErr (4-bit counter)

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
Req  in  1  access request, sampled in IDLE only
Wr  in  1  1 store, 0 load
Size  in  2  00 byte, 01 half, 10 word, 11 illegal
Signed  in  1  load sign-extend enable
Addr  in  32  byte address
WrData  in  32  store data, right-justified
MemCS  out  1  memory chip select (one-cycle strobe)
MemRW  out  1  1 write, 0 read
MemBE  out  4  byte enables
MemAddr  out  30  word address = Addr[31:2]
MemDataOut  out  32  write data to memory
MemDataIn  in  32  read data from memory
MemDataReady  in  1  memory data valid/complete
Busy  out  1  pipeline stall
Done  out  1  one-cycle completion pulse
RdData  out  32  extended load result
AddrErr  out  1  one-cycle misalignment/illegal-size pulse
BusErr  out  1  one-cycle timeout pulse

Behaviour:
- Reset low (async): state IDLE. All outputs 0. Captured request and timeout counter cleared. Any strobe in flight is dropped; no further memory cycle is issued.
- Ports change only on rising Clk. Little-endian lanes: byte k = bits [8k+7:8k].
- States: IDLE, RD, RWAIT, MERGE, WR, DONE, ERR.
- IDLE: Busy=0. When Req=1, capture Wr/Size/Signed/Addr/WrData.
  - Misaligned (half with Addr[0]=1, word with Addr[1:0]!=0) or Size=11 goes to ERR. No memory strobe is issued.
  - Otherwise: load or RMW sub-word store goes to RD; word store (or sub-word with RMW_EN=0) goes to WR.
- Busy=1 in every state except IDLE. Req is ignored while Busy.
- RD (1 cycle): MemCS=1, MemRW=0, MemBE=1111, MemAddr=Addr[31:2]. Next: RWAIT, counter=0.
- RWAIT: MemCS=0.
  - MemDataReady=1: capture MemDataIn into the read buffer. Load goes to DONE; store goes to MERGE.
  - MemDataReady=0: counter+1. If counter==TIMEOUT, pulse BusErr and go IDLE; Done is not asserted.
- MERGE (1 cycle): replace the addressed lane(s) of the buffer with WrData[7:0] or WrData[15:0]. Next: WR.
- WR (1 cycle): MemCS=1, MemRW=1, MemAddr as above.
  - MemDataOut = merged word, or WrData shifted to its lane.
  - MemBE = 1111 for RMW or word. With RMW_EN=0: 0001<<Addr[1:0] for byte, 0011<<Addr[1:0] for half.
  - Next: DONE. Writes do not wait on DataReady.
- DONE (1 cycle): Done=1. For loads, RdData updates in this cycle.
  - Byte: lane Addr[1:0]. Half: lanes Addr[1], Addr[1]+1.
  - Extended to 32 bits: sign if Signed=1, else zero. Word: unmodified.
  - RdData holds until the next load's DONE. Next: IDLE.
- ERR (1 cycle): AddrErr=1, Busy=1, RdData unchanged. Next: IDLE.
- Latency with a ready-next-cycle memory, Req at edge 0:
  - Load: Done in cycle 3.
  - Word store: Done in cycle 2.
  - RMW store: Done in cycle 5.
  - Error: AddrErr in cycle 1.
- MemCS is never high in two consecutive cycles. MemBE=0000 whenever MemCS=0.

Decomposition:
- Package mem_access_pkg holds:
  - Size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - State enum.
  - TIMEOUT counter width constant.
  - Functions be_for() and lane_extract().
- Sub-module mem_lane_align (combinational) holds load lane-extract/extend and store lane-merge/shift. It is instantiated once.

Test Plan:
- Load word: mem[1]=0x8899AABB, Req Wr=0 Size=10 Addr=0x4 → MemCS read at cycle 1, Done cycle 3, RdData=0x8899AABB.
- Signed byte load: mem[0]=0x000080FF, Addr=0x1 Signed=1 → RdData=0xFFFFFF80. Repeat with Signed=0 → 0x00000080.
- RMW half store: mem[2]=0x11223344, Addr=0xA Size=01 WrData=0xBEEF → one read, one write with BE=1111, data 0xBEEF3344, Done cycle 5.
- Misaligned: Size=10 Addr=0x6 → AddrErr pulse cycle 1, MemCS never asserted, RdData unchanged.
- Timeout: hold MemDataReady=0 during a load → BusErr after 15 RWAIT cycles, no Done, Busy drops the next cycle.
- Reset low during RWAIT → all outputs 0 immediately. After release, a fresh load completes normally.

Source files
------------

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared size encodings, FSM states and lane helpers for the load/store unit
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam int         CNT_W   = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RWAIT,
        S_MERGE,
        S_WR,
        S_DONE,
        S_ERR
    } state_t;

    function automatic logic [3:0] be_for(input logic [1:0] size, input logic [1:0] off);
        return size == SZ_BYTE ? 4'b0001 << off : size == SZ_HALF ? 4'b0011 << off : 4'b1111;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return size == 2'b11 || (size == SZ_HALF && off[0]) || (size == SZ_WORD && off != 2'b00);
    endfunction

    function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] off, input logic sgn);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        if (size == SZ_BYTE) return {{24{sgn & sh[7]}}, sh[7:0]};
        if (size == SZ_HALF) return {{16{sgn & sh[15]}}, sh[15:0]};
        return word;
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// mem_access_if: pipeline-side request/response and memory word bus of the load/store unit
interface mem_access_if;

    logic        Req;
    logic        Wr;
    logic [1:0]  Size;
    logic        Signed;
    logic [31:0] Addr;
    logic [31:0] WrData;
    logic        MemCS;
    logic        MemRW;
    logic [3:0]  MemBE;
    logic [29:0] MemAddr;
    logic [31:0] MemDataOut;
    logic [31:0] MemDataIn;
    logic        MemDataReady;
    logic        Busy;
    logic        Done;
    logic [31:0] RdData;
    logic        AddrErr;
    logic        BusErr;

    modport slave (
        input  Req, Wr, Size, Signed, Addr, WrData, MemDataIn, MemDataReady,
        output MemCS, MemRW, MemBE, MemAddr, MemDataOut, Busy, Done, RdData, AddrErr, BusErr
    );

    modport master (
        output Req, Wr, Size, Signed, Addr, WrData, MemDataIn, MemDataReady,
        input  MemCS, MemRW, MemBE, MemAddr, MemDataOut, Busy, Done, RdData, AddrErr, BusErr
    );

endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: load lane extract/extend and store lane shift/merge
import mem_access_pkg::*;

module mem_lane_align (
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        sgn_i,
    input  logic [31:0] rd_word_i,
    input  logic [31:0] buf_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] st_shift_o,
    output logic [31:0] st_merge_o
);

    logic [3:0]  be;
    logic [31:0] mask;
    logic [31:0] wd;

    // Lane mask from the byte enables; store data is trimmed to its size before shifting
    always_comb begin
        be         = be_for(size_i, off_i);
        mask       = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        wd         = size_i == SZ_BYTE ? {24'h0, wdata_i[7:0]} :
                     size_i == SZ_HALF ? {16'h0, wdata_i[15:0]} : wdata_i;
        st_shift_o = wd << {off_i, 3'b000};
        st_merge_o = (buf_i & ~mask) | (st_shift_o & mask);
        ld_data_o  = lane_extract(rd_word_i, size_i, off_i, sgn_i);
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer with alignment check, read-merge-write and read timeout
import mem_access_pkg::*;

module mem_access_unit #(
    parameter bit RMW_EN  = 1'b1,
    parameter int TIMEOUT = 15
) (
    input logic         Clk,
    input logic         Reset,
    mem_access_if.slave bus
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic [1:0]         size_q, size_d;
    logic               sgn_q, sgn_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        buf_q, buf_d;
    logic [31:0]        rd_q, rd_d;
    logic               buserr_q, buserr_d;
    logic [31:0]        ld_data, st_shift, st_merge;
    logic               use_buf;

    mem_lane_align u_align (
        .size_i     (size_q),
        .off_i      (addr_q[1:0]),
        .sgn_i      (sgn_q),
        .rd_word_i  (bus.MemDataIn),
        .buf_i      (buf_q),
        .wdata_i    (wdata_q),
        .ld_data_o  (ld_data),
        .st_shift_o (st_shift),
        .st_merge_o (st_merge)
    );

    assign use_buf = RMW_EN && size_q != SZ_WORD;

    // State and captured request; reset drops any access in flight
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            wr_q     <= 1'b0;
            size_q   <= SZ_BYTE;
            sgn_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            buf_q    <= '0;
            rd_q     <= '0;
            buserr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            size_q   <= size_d;
            sgn_q    <= sgn_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            buf_q    <= buf_d;
            rd_q     <= rd_d;
            buserr_q <= buserr_d;
        end
    end

    // Next-state sequencing; load result is extended as it arrives so RdData is valid in DONE
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        size_d   = size_q;
        sgn_d    = sgn_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        buf_d    = buf_q;
        rd_d     = rd_q;
        buserr_d = 1'b0;
        case (state_q)
            S_IDLE: if (bus.Req) begin
                wr_d    = bus.Wr;
                size_d  = bus.Size;
                sgn_d   = bus.Signed;
                addr_d  = bus.Addr;
                wdata_d = bus.WrData;
                state_d = misaligned(bus.Size, bus.Addr[1:0]) ? S_ERR :
                          (!bus.Wr || (RMW_EN && bus.Size != SZ_WORD)) ? S_RD : S_WR;
            end
            S_RD: begin
                cnt_d   = '0;
                state_d = S_RWAIT;
            end
            S_RWAIT: if (bus.MemDataReady) begin
                buf_d   = bus.MemDataIn;
                rd_d    = wr_q ? rd_q : ld_data;
                state_d = wr_q ? S_MERGE : S_DONE;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                buserr_d = 1'b1;
                state_d  = S_IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            S_MERGE: begin
                buf_d   = st_merge;
                state_d = S_WR;
            end
            S_WR:    state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.Busy       = state_q != S_IDLE;
    assign bus.MemCS      = state_q == S_RD || state_q == S_WR;
    assign bus.MemRW      = state_q == S_WR;
    assign bus.MemBE      = state_q == S_RD ? 4'hF :
                            state_q == S_WR ? (RMW_EN ? 4'hF : be_for(size_q, addr_q[1:0])) : 4'h0;
    assign bus.MemAddr    = addr_q[31:2];
    assign bus.MemDataOut = state_q == S_WR ? (use_buf ? buf_q : st_shift) : 32'h0;
    assign bus.Done       = state_q == S_DONE;
    assign bus.AddrErr    = state_q == S_ERR;
    assign bus.BusErr     = buserr_q;
    assign bus.RdData     = rd_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of loads, stores, errors, timeout and reset
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [31:0] mem [16];
    logic        stall = 1'b0;
    logic        pend = 1'b0;
    logic [31:0] pdata = '0;
    logic        prev_cs = 1'b0;
    int          cs_b2b = 0;
    int          be_viol = 0;
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc, end_cyc, rd_cyc, wr_cyc, ncs;
    logic [3:0]  wr_be;
    logic [31:0] wr_dat;
    logic        saw_done, saw_addrerr, saw_buserr, busy_end;

    mem_access_if bus ();

    mem_access_unit #(.RMW_EN(1'b1), .TIMEOUT(15)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        bus.MemDataReady = pend;
        bus.MemDataIn    = pend ? pdata : 32'h0;
        pend = 1'b0;
        if (bus.MemCS && !bus.MemRW && !stall) begin
            pend  = 1'b1;
            pdata = mem[bus.MemAddr[3:0]];
        end
        if (bus.MemCS && bus.MemRW)
            mem[bus.MemAddr[3:0]] = bus.MemDataOut &
                {{8{bus.MemBE[3]}}, {8{bus.MemBE[2]}}, {8{bus.MemBE[1]}}, {8{bus.MemBE[0]}}};
        if (bus.MemCS && prev_cs) cs_b2b++;
        if (!bus.MemCS && bus.MemBE != 4'h0) be_viol++;
        prev_cs = bus.MemCS;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic access(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd);
        bus.Req = 1'b1; bus.Wr = w; bus.Size = sz; bus.Signed = sg; bus.Addr = a; bus.WrData = wd;
        @(posedge Clk); #1;
        bus.Req = 1'b0;
        cyc = 1; end_cyc = 0; rd_cyc = 0; wr_cyc = 0; ncs = 0; wr_be = '0; wr_dat = '0;
        saw_done = 0; saw_addrerr = 0; saw_buserr = 0; busy_end = 0;
        while (cyc <= 40 && end_cyc == 0) begin
            if (bus.MemCS) begin
                ncs++;
                if (!bus.MemRW && rd_cyc == 0) rd_cyc = cyc;
                if (bus.MemRW) begin
                    wr_cyc = cyc; wr_be = bus.MemBE; wr_dat = bus.MemDataOut;
                end
            end
            if (bus.Done || bus.AddrErr || bus.BusErr) begin
                end_cyc = cyc; saw_done = bus.Done; saw_addrerr = bus.AddrErr;
                saw_buserr = bus.BusErr; busy_end = bus.Busy;
            end else begin
                @(posedge Clk); #1;
                cyc++;
            end
        end
        if (end_cyc == 0) check("access_bound", 32'(cyc), 32'd40);
        @(posedge Clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no end expected end");
        $fatal(1, "watchdog");
    end

    initial begin
        foreach (mem[i]) mem[i] = '0;
        mem[0] = 32'h000080FF; mem[1] = 32'h8899AABB; mem[2] = 32'h11223344; mem[3] = 32'hCAFEF00D;
        bus.Req = 0; bus.Wr = 0; bus.Size = 0; bus.Signed = 0; bus.Addr = 0; bus.WrData = 0;
        bus.MemDataIn = 0; bus.MemDataReady = 0;
        repeat (2) @(posedge Clk);
        #1;
        check("reset_ctrl", 32'({bus.Busy, bus.Done, bus.MemCS, bus.MemRW, bus.AddrErr, bus.BusErr, bus.MemBE}), 0);
        check("reset_rddata", bus.RdData, 0);
        Reset = 1'b1;
        @(posedge Clk); #1;

        access(0, SZ_WORD, 0, 32'h4, 0);
        check("ldw_rd_cyc", 32'(rd_cyc), 1);
        check("ldw_done_cyc", 32'(end_cyc), 3);
        check("ldw_done", 32'(saw_done), 1);
        check("ldw_ncs", 32'(ncs), 1);
        check("ldw_data", bus.RdData, 32'h8899AABB);

        access(0, SZ_BYTE, 1, 32'h1, 0);
        check("ldb_s_cyc", 32'(end_cyc), 3);
        check("ldb_s_data", bus.RdData, 32'hFFFFFF80);
        access(0, SZ_BYTE, 0, 32'h1, 0);
        check("ldb_u_data", bus.RdData, 32'h00000080);
        access(0, SZ_HALF, 1, 32'h6, 0);
        check("ldh_s_data", bus.RdData, 32'hFFFF8899);

        access(1, SZ_HALF, 0, 32'hA, 32'h0000BEEF);
        check("sth_rd_cyc", 32'(rd_cyc), 1);
        check("sth_wr_cyc", 32'(wr_cyc), 4);
        check("sth_be", 32'(wr_be), 32'hF);
        check("sth_wdata", wr_dat, 32'hBEEF3344);
        check("sth_done_cyc", 32'(end_cyc), 5);
        check("sth_ncs", 32'(ncs), 2);
        check("sth_mem", mem[2], 32'hBEEF3344);
        check("sth_rddata", bus.RdData, 32'hFFFF8899);

        access(1, SZ_BYTE, 0, 32'hD, 32'hFFFFFF5A);
        check("stb_done_cyc", 32'(end_cyc), 5);
        check("stb_mem", mem[3], 32'hCAFE5A0D);

        access(1, SZ_WORD, 0, 32'h0, 32'h12345678);
        check("stw_wr_cyc", 32'(wr_cyc), 1);
        check("stw_done_cyc", 32'(end_cyc), 2);
        check("stw_ncs", 32'(ncs), 1);
        check("stw_mem", mem[0], 32'h12345678);

        access(0, SZ_WORD, 0, 32'h6, 0);
        check("misw_err", 32'(saw_addrerr), 1);
        check("misw_cyc", 32'(end_cyc), 1);
        check("misw_ncs", 32'(ncs), 0);
        check("misw_rddata", bus.RdData, 32'hFFFF8899);
        access(0, 2'b11, 0, 32'h0, 0);
        check("size11_err", 32'({saw_addrerr, saw_done}), 32'b10);
        access(1, SZ_HALF, 0, 32'h3, 32'h1);
        check("mish_err", 32'(saw_addrerr), 1);
        check("mish_ncs", 32'(ncs), 0);

        stall = 1'b1;
        access(0, SZ_WORD, 0, 32'h8, 0);
        check("to_buserr", 32'(saw_buserr), 1);
        check("to_cyc", 32'(end_cyc), 17);
        check("to_nodone", 32'(saw_done), 0);
        check("to_busy", 32'(busy_end), 0);
        check("to_rddata", bus.RdData, 32'hFFFF8899);

        bus.Req = 1'b1; bus.Wr = 1'b0; bus.Size = SZ_WORD; bus.Signed = 1'b0; bus.Addr = 32'h4;
        @(posedge Clk); #1;
        bus.Req = 1'b0;
        @(posedge Clk); #1;
        check("rst_pre_busy", 32'(bus.Busy), 1);
        #2 Reset = 1'b0;
        #1;
        check("rst_mid_ctrl", 32'({bus.Busy, bus.Done, bus.MemCS, bus.MemRW, bus.AddrErr, bus.BusErr, bus.MemBE}), 0);
        check("rst_mid_rddata", bus.RdData, 0);
        check("rst_mid_addr", 32'(bus.MemAddr), 0);
        @(posedge Clk); #1;
        Reset = 1'b1;
        stall = 1'b0;
        @(posedge Clk); #1;
        access(0, SZ_WORD, 0, 32'h4, 0);
        check("post_rst_cyc", 32'(end_cyc), 3);
        check("post_rst_data", bus.RdData, 32'h8899AABB);

        check("cs_back2back", 32'(cs_b2b), 0);
        check("be_when_idle", 32'(be_viol), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
